// File: rtl/blink_sequencer_pkg.sv
// Shared board-level constants: blink FSM state encoding and the 25 MHz tick divider.
// No logic; imported by the blink sequencer and any block that decodes its state.
package blink_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // 1 ms tick at the 25 MHz board clock
  localparam int DEFAULT_TICK_DIV = 25000;

endpackage

// File: rtl/blink_sequencer_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles, combinational off the count.
// Held at zero by clear; counts only while en is high, with no stall input.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/blink_sequencer.sv
// Drives the LED through count on/off blinks with latched durations; busy/done for chaining.
// Outputs registered, one cycle after start is sampled; stop aborts with no done pulse.
module blink_sequencer
  import blink_sequencer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int TIME_W   = 16,
  parameter int COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [TIME_W-1:0]  on_ticks,
  input  logic [TIME_W-1:0]  off_ticks,
  input  logic [COUNT_W-1:0] count,
  output logic               led,
  output logic               busy,
  output logic               done
);

  state_t             state_q;
  logic [TIME_W-1:0]  on_q;
  logic [TIME_W-1:0]  off_q;
  logic [TIME_W-1:0]  phase_q;
  logic [COUNT_W-1:0] rem_q;
  logic               led_q;
  logic               busy_q;
  logic               done_q;

  logic               tick;
  logic               tick_clear;
  logic [TIME_W:0]    phase_d;
  logic [TIME_W:0]    phase_len;
  logic               phase_end;

  // Prescaler idles at zero outside a run so every pattern starts on a fresh tick boundary
  assign tick_clear = (state_q == ST_IDLE) || stop;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .en    (busy_q),
    .tick  (tick)
  );

  // Extra bit keeps the compare exact even for the maximum duration
  assign phase_d   = {1'b0, phase_q} + {{TIME_W{1'b0}}, 1'b1};
  assign phase_len = {1'b0, (state_q == ST_ON) ? on_q : off_q};
  assign phase_end = tick && (phase_d == phase_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      on_q    <= '0;
      off_q   <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !stop && (count != '0)) begin
            on_q    <= (on_ticks  == '0) ? TIME_W'(1) : on_ticks;
            off_q   <= (off_ticks == '0) ? TIME_W'(1) : off_ticks;
            rem_q   <= count;
            phase_q <= '0;
            state_q <= ST_ON;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_ON, ST_OFF: begin
          if (stop) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (phase_end) begin
            phase_q <= '0;
            if (state_q == ST_ON) begin
              state_q <= ST_OFF;
              led_q   <= 1'b0;
            end else if (rem_q > COUNT_W'(1)) begin
              rem_q   <= rem_q - 1'b1;
              state_q <= ST_ON;
              led_q   <= 1'b1;
            end else begin
              rem_q   <= '0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (tick) begin
            phase_q <= phase_d[TIME_W-1:0];
          end
        end
        default: begin
          state_q <= ST_IDLE;
          phase_q <= '0;
          rem_q   <= '0;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
